// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller.
//   SEG_0..SEG_F : segment codes, [0:6] = a..g, active-low
//   SEG_OFF      : all segments dark
//   ANODE_OFF    : all anodes dark (sliced to NUM_DIGITS by users)
//   DEF_REFRESH_DIV : slot length for the 100 MHz board clock (2 kHz per slot)
package sseg_pkg;

  localparam int MAX_DIGITS      = 8;
  localparam int DEF_REFRESH_DIV = 50000;

  localparam logic [0:6] SEG_0   = 7'b0000001;
  localparam logic [0:6] SEG_1   = 7'b1001111;
  localparam logic [0:6] SEG_2   = 7'b0010010;
  localparam logic [0:6] SEG_3   = 7'b0000110;
  localparam logic [0:6] SEG_4   = 7'b1001100;
  localparam logic [0:6] SEG_5   = 7'b0100100;
  localparam logic [0:6] SEG_6   = 7'b0100000;
  localparam logic [0:6] SEG_7   = 7'b0001111;
  localparam logic [0:6] SEG_8   = 7'b0000000;
  localparam logic [0:6] SEG_9   = 7'b0000100;
  localparam logic [0:6] SEG_A   = 7'b0001000;
  localparam logic [0:6] SEG_B   = 7'b1100000;
  localparam logic [0:6] SEG_C   = 7'b0110001;
  localparam logic [0:6] SEG_D   = 7'b1000010;
  localparam logic [0:6] SEG_E   = 7'b0110000;
  localparam logic [0:6] SEG_F   = 7'b0111000;
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to seven-segment decoder.
//   nib : 4-bit hex value
//   seg : segments [0:6] = a..g, active-low
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment display scanner with double-buffered host writes.
//   clk, rst_n  : clock, async active-low reset
//   wr_en       : one-cycle write strobe for wr_data / wr_mask
//   wr_data     : nibble i = digit i (digit 0 rightmost)
//   wr_mask     : 1 = digit enabled
//   upd_done    : pulse when new data reaches the shadow buffer
//   frame_start : pulse on the cycle the scan wraps to digit 0
//   an          : active-low anodes, at most one low
//   SSeg        : active-low segments [0:6] = a..g
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = 2,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_mask,
  output logic                    upd_done,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [0:6]              SSeg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic          tick, wrap;

  logic [NUM_DIGITS-1:0][3:0] pend_data, shadow_data;
  logic [NUM_DIGITS-1:0]      pend_mask, shadow_mask;
  logic                       pend;

  logic [NUM_DIGITS-1:0] hi_zero, sel;
  logic                  acc, lz_blank, visible, guard;
  logic [0:6]            dec_seg;

  assign tick = (count == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  // Slot/digit position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      count       <= tick ? '0 : count + 1'b1;
      frame_start <= wrap;
      if (tick) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: the shadow only changes on the frame-wrap edge. A write
  // landing exactly on that edge bypasses the pending regs so it is not
  // delayed a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data   <= '0;
      pend_mask   <= '0;
      pend        <= 1'b0;
      shadow_data <= '0;
      shadow_mask <= '0;
      upd_done    <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      if (wrap && wr_en) begin
        shadow_data <= wr_data;
        shadow_mask <= wr_mask;
        pend        <= 1'b0;
        upd_done    <= 1'b1;
      end else if (wrap && pend) begin
        shadow_data <= pend_data;
        shadow_mask <= pend_mask;
        pend        <= 1'b0;
        upd_done    <= 1'b1;
      end else if (wr_en) begin
        pend_data <= wr_data;
        pend_mask <= wr_mask;
        pend      <= 1'b1;
      end
    end
  end

  // hi_zero[i]: nibbles i..N-1 are all zero (digit i is a leading zero)
  always_comb begin
    hi_zero = '0;
    acc     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc        = acc && (shadow_data[i] == 4'h0);
      hi_zero[i] = acc;
    end
  end

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

  assign lz_blank = LZ_SUPPRESS && (idx != '0) && hi_zero[idx];
  assign visible  = shadow_mask[idx] && !lz_blank;
  assign guard    = (count < CW'(BLANK_CYC));

  hex_to_sseg u_dec (
    .nib (shadow_data[idx]),
    .seg (dec_seg)
  );

  // an and SSeg registered together so they switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= ANODE_OFF[NUM_DIGITS-1:0];
      SSeg <= SEG_OFF;
    end else if (guard || !visible) begin
      an   <= ANODE_OFF[NUM_DIGITS-1:0];
      SSeg <= SEG_OFF;
    end else begin
      an   <= ~sel;
      SSeg <= dec_seg;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed, table-driven bench for sseg_scan_ctrl (8 digits, 4-cycle slots,
// 1 guard cycle, leading-zero suppression on).
module tb_sseg_scan_ctrl;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic [7:0]    wr_mask;
  logic          upd_done, frame_start;
  logic [7:0]    an;
  logic [0:6]    SSeg;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV),
    .BLANK_CYC  (1),
    .LZ_SUPPRESS(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .upd_done   (upd_done),
    .frame_start(frame_start),
    .an         (an),
    .SSeg       (SSeg)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    int          wpos;  // frame cycle whose closing edge samples the write
    int          nwr;   // 0 none, 1 single, 2 junk at cycle 5 then real
    logic [7:0]  vis;   // digits expected to light
  } row_t;

  row_t rows[9];
  row_t blank_row;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'b0000001; 4'h1: dec = 7'b1001111;
      4'h2: dec = 7'b0010010; 4'h3: dec = 7'b0000110;
      4'h4: dec = 7'b1001100; 4'h5: dec = 7'b0100100;
      4'h6: dec = 7'b0100000; 4'h7: dec = 7'b0001111;
      4'h8: dec = 7'b0000000; 4'h9: dec = 7'b0000100;
      4'hA: dec = 7'b0001000; 4'hB: dec = 7'b1100000;
      4'hC: dec = 7'b0110001; 4'hD: dec = 7'b1000010;
      4'hE: dec = 7'b0110000; default: dec = 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Checks one whole frame against 'disp' while issuing the writes in 'w'.
  // Entered with cyc on a frame boundary.
  task automatic check_frame(input row_t disp, input row_t w);
    logic [7:0] one;
    logic [7:0] ea;
    logic [6:0] es;
    int         i, c;
    one = 8'h01;
    for (int j = 0; j < FR; j++) begin
      if (w.nwr == 2 && j == 5) begin
        wr_en = 1'b1; wr_data = 32'h12345678; wr_mask = 8'hFF;
      end
      if (w.nwr != 0 && j == w.wpos) begin
        wr_en = 1'b1; wr_data = w.data; wr_mask = w.mask;
      end
      step();
      wr_en = 1'b0;
      i = j / DIV;
      c = j % DIV;
      if (c == 0 || !disp.vis[i]) begin
        ea = 8'hFF; es = 7'b1111111;
      end else begin
        ea = ~(one << i); es = dec(disp.data[4*i +: 4]);
      end
      chk("an", {24'h0, an}, {24'h0, ea});
      chk("SSeg", {25'h0, SSeg}, {25'h0, es});
      chk("frame_start", {31'h0, frame_start}, {31'h0, (j == FR - 1)});
      chk("upd_done", {31'h0, upd_done}, {31'h0, (j == FR - 1 && w.nwr != 0)});
    end
  endtask

  // Whole-run invariant: one anode at most, and dark during guard cycles
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_assert++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL onehot_an cyc=%0d got %h expected at most one low", cyc, an);
      end
      if (cyc >= 1 && ((cyc - 1) % DIV) == 0) begin
        n_assert++;
        if (an !== 8'hFF) begin
          n_fail++;
          $display("FAIL guard_an cyc=%0d got %h expected ff", cyc, an);
        end
      end
    end
  end

  initial begin
    rows[0] = '{32'h76543210, 8'hFF, 10, 1, 8'hFF};
    rows[1] = '{32'hFFFFFFFF, 8'hFF, 14, 1, 8'hFF};
    rows[2] = '{32'hABCDEF01, 8'hFF, 31, 2, 8'hFF};
    rows[3] = '{32'hABCDEF01, 8'hFF,  0, 0, 8'hFF};
    rows[4] = '{32'h00000305, 8'hFF, 20, 2, 8'h07};
    rows[5] = '{32'h00000305, 8'hFE,  0, 1, 8'h06};
    rows[6] = '{32'h89ABCDEF, 8'h5A, 27, 2, 8'h5A};
    rows[7] = '{32'h00000000, 8'hFF, 31, 1, 8'h01};
    rows[8] = '{32'h80000000, 8'hFF,  8, 2, 8'hFF};
    blank_row = '{32'h0, 8'h00, 0, 0, 8'h00};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_SSeg", {25'h0, SSeg}, 32'h7F);
    chk("rst_upd_done", {31'h0, upd_done}, 32'h0);
    chk("rst_frame_start", {31'h0, frame_start}, 32'h0);
    rst_n = 1'b1;
    cyc = 0;

    begin
      row_t prev;
      prev = blank_row;
      for (int r = 0; r < 9; r++) begin
        check_frame(prev, rows[r]);
        if (rows[r].nwr != 0) prev = rows[r];
      end
      check_frame(prev, blank_row);
    end

    // Reset mid-slot with a write still pending: outputs go dark at once,
    // pending data is dropped and the scan restarts at digit 0.
    wr_en = 1'b1; wr_data = 32'h11111111; wr_mask = 8'hFF;
    step();
    wr_en = 1'b0;
    repeat (10) step();
    chk("pre_reset_an", {24'h0, an}, 32'hFB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {24'h0, an}, 32'hFF);
    chk("async_rst_SSeg", {25'h0, SSeg}, 32'h7F);
    chk("async_rst_upd_done", {31'h0, upd_done}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    check_frame(blank_row, blank_row);
    check_frame(blank_row, rows[0]);
    check_frame(rows[0], blank_row);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
